// File: rtl/rtype_issue.sv
// R-type issue/writeback stage: decode, regfile read, ALU drive, write-back.
// Optional OP-IMM support is enabled with `define RTYPE_ISSUE_OP_IMM_EN.
module rtype_issue #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic        alu_enable,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [31:0] alu_operand_1,
  output logic [31:0] alu_operand_2,
  input  logic [31:0] alu_result,
  output logic        retire_valid,
  output logic [4:0]  retire_rd,
  output logic [31:0] retire_data,
  output logic        illegal_instr,
  input  logic        debug_we,
  input  logic [4:0]  debug_addr,
  input  logic [31:0] debug_wdata,
  output logic [31:0] debug_rdata
);

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [3:0] CNT_INIT = 4'(ALU_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    REJECT,
    READ,
    EXEC,
    WB
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:7] ir;
  logic [3:0]  cnt;
  logic [31:0] regs [32];
  logic        hs;
  logic        legal;
  logic [31:0] op2_nxt;
  logic [6:0]  f7_nxt;

  wire [6:0] in_op = instr[6:0];
  wire [2:0] in_f3 = instr[14:12];
  wire [6:0] in_f7 = instr[31:25];
  wire [4:0] rd    = ir[11:7];
  wire [4:0] rs1   = ir[19:15];
  wire [4:0] rs2   = ir[24:20];

`ifdef RTYPE_ISSUE_OP_IMM_EN
  logic imm_op;
`endif

  assign hs            = instr_valid & instr_ready;
  assign instr_ready   = (state == IDLE);
  assign alu_enable    = (state == EXEC);
  assign retire_valid  = (state == WB);
  assign illegal_instr = (state == REJECT);
  assign debug_rdata   = (debug_addr == 5'd0) ? 32'd0 : regs[debug_addr];

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      (in_op == OP_REG): begin
        legal = (in_f7 == 7'h00) ||
                ((in_f7 == 7'h20) &&
                 ((in_f3 == 3'b000) || (in_f3 == 3'b101)));
      end
`ifdef RTYPE_ISSUE_OP_IMM_EN
      (in_op == OP_IMM): begin
        legal = 1'b1;
        if (in_f3 == 3'b001)
          legal = (in_f7 == 7'h00);
        else if (in_f3 == 3'b101)
          legal = (in_f7 == 7'h00) || (in_f7 == 7'h20);
      end
`endif
      default: legal = 1'b0;
    endcase
  end

  // Second operand and funct7 as presented to the ALU in EXEC.
  always_comb begin
    op2_nxt = regs[rs2];
    f7_nxt  = ir[31:25];
`ifdef RTYPE_ISSUE_OP_IMM_EN
    if (imm_op) begin
      op2_nxt = {{20{ir[31]}}, ir[31:20]};
      if ((ir[14:12] != 3'b001) && (ir[14:12] != 3'b101))
        f7_nxt = 7'h00;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (hs) state_nxt = legal ? READ : REJECT;
      REJECT:  state_nxt = IDLE;
      READ:    state_nxt = EXEC;
      EXEC:    if (cnt == 4'd0) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir            <= '0;
      cnt           <= '0;
      alu_funct3    <= '0;
      alu_funct7    <= '0;
      alu_operand_1 <= '0;
      alu_operand_2 <= '0;
      retire_rd     <= '0;
      retire_data   <= '0;
`ifdef RTYPE_ISSUE_OP_IMM_EN
      imm_op        <= 1'b0;
`endif
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            ir <= instr[31:7];
`ifdef RTYPE_ISSUE_OP_IMM_EN
            imm_op <= (in_op == OP_IMM);
`endif
          end else if (debug_we && (debug_addr != 5'd0)) begin
            regs[debug_addr] <= debug_wdata;
          end
        end
        READ: begin
          alu_operand_1 <= regs[rs1];
          alu_operand_2 <= op2_nxt;
          alu_funct3    <= ir[14:12];
          alu_funct7    <= f7_nxt;
          cnt           <= CNT_INIT;
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            retire_data <= alu_result;
            retire_rd   <= rd;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WB: begin
          if (rd != 5'd0) regs[rd] <= retire_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtype_issue.sv
// Scoreboard bench for rtype_issue with a behavioural ALU model.
// Build with +define+RTYPE_ISSUE_OP_IMM_EN to exercise OP-IMM.
module tb_rtype_issue;

  localparam int LAT = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic        alu_enable;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_operand_1;
  logic [31:0] alu_operand_2;
  logic [31:0] alu_result;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data;
  logic        illegal_instr;
  logic        debug_we = 1'b0;
  logic [4:0]  debug_addr = '0;
  logic [31:0] debug_wdata = '0;
  logic [31:0] debug_rdata;

  rtype_issue #(.ALU_LATENCY(LAT)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .alu_enable(alu_enable),
    .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7),
    .alu_operand_1(alu_operand_1),
    .alu_operand_2(alu_operand_2),
    .alu_result(alu_result),
    .retire_valid(retire_valid),
    .retire_rd(retire_rd),
    .retire_data(retire_data),
    .illegal_instr(illegal_instr),
    .debug_we(debug_we),
    .debug_addr(debug_addr),
    .debug_wdata(debug_wdata),
    .debug_rdata(debug_rdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  f3,
    input logic [6:0]  f7
  );
    case (f3)
      3'd0: return f7[5] ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_operand_1, alu_operand_2,
                                 alu_funct3, alu_funct7);

  function automatic bit legal_f(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    if (op == 7'h33)
      return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
`ifdef RTYPE_ISSUE_OP_IMM_EN
    if (op == 7'h13) begin
      if (f3 == 3'd1) return f7 == 7'h00;
      if (f3 == 3'd5) return f7 == 7'h00 || f7 == 7'h20;
      return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    bit          ill;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  logic [31:0] m_reg [32];
  int          checks = 0;
  int          errors = 0;
  int          en_cnt = 0;
  bit          prev_en = 1'b0;
  bit          prev_ill = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (prev_ill) chk("ill_ready", {31'd0, instr_ready}, 32'd1);
      prev_ill = illegal_instr;
      if (alu_enable) begin
        chk("exec_ready", {31'd0, instr_ready}, 32'd0);
        if (q.size() == 0) begin
          chk("en_unexp", {31'd0, alu_enable}, 32'd0);
        end else if (!prev_en) begin
          chk("op1", alu_operand_1, q[0].op1);
          chk("op2", alu_operand_2, q[0].op2);
          chk("f3", {29'd0, alu_funct3}, {29'd0, q[0].f3});
          chk("f7", {25'd0, alu_funct7}, {25'd0, q[0].f7});
        end
        en_cnt++;
      end
      prev_en = alu_enable;
      if (retire_valid) begin
        if (q.size() == 0) begin
          chk("ret_unexp", {31'd0, retire_valid}, 32'd0);
        end else begin
          me = q.pop_front();
          chk("ret_kind", {31'd0, me.ill}, 32'd0);
          chk("ret_rd", {27'd0, retire_rd}, {27'd0, me.rd});
          chk("ret_data", retire_data, me.data);
          chk("ret_cyc", cyc, me.cyc + 1 + LAT);
          chk("en_cycles", en_cnt, LAT);
          if (me.rd != 5'd0) m_reg[me.rd] = me.data;
        end
        en_cnt = 0;
      end
      if (illegal_instr) begin
        if (q.size() == 0) begin
          chk("ill_unexp", {31'd0, illegal_instr}, 32'd0);
        end else begin
          me = q.pop_front();
          chk("ill_kind", {31'd0, me.ill}, 32'd1);
          chk("ill_cyc", cyc, me.cyc);
          chk("ill_no_en", en_cnt, 0);
        end
        en_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] w, input bit hold,
                       input bit collide);
    exp_t e;
    logic [31:0] b;
    logic [6:0]  f7;
    instr_valid = 1'b1;
    instr = w;
    for (int i = 0; i < 50 && !instr_ready; i++) @(negedge clock);
    if (!instr_ready) begin
      chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
      instr_valid = 1'b0;
      return;
    end
    if (collide) begin
      debug_we = 1'b1;
      debug_addr = 5'd7;
      debug_wdata = 32'd99;
    end
    b = m_reg[w[24:20]];
    f7 = w[31:25];
    if (w[6:0] == 7'h13) begin
      b = {{20{w[31]}}, w[31:20]};
      if (w[14:12] != 3'd1 && w[14:12] != 3'd5) f7 = 7'h00;
    end
    e.rd = w[11:7];
    e.op1 = m_reg[w[19:15]];
    e.op2 = b;
    e.f3 = w[14:12];
    e.f7 = f7;
    e.data = alu_f(e.op1, b, e.f3, f7);
    e.ill = !legal_f(w);
    e.cyc = cyc + 1;
    q.push_back(e);
    @(posedge clock);
    #1;
    debug_we = 1'b0;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clock);
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(negedge clock);
  endtask

  task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    debug_we = 1'b1;
    debug_addr = a;
    debug_wdata = d;
    @(negedge clock);
    debug_we = 1'b0;
    if (a != 5'd0) m_reg[a] = d;
  endtask

  task automatic dbg_read(input logic [4:0] a);
    debug_addr = a;
    #1;
    chk($sformatf("dbg_x%0d", a), debug_rdata, m_reg[a]);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    #1;
    chk("rst_en", {31'd0, alu_enable}, 32'd0);
    chk("rst_ret", {31'd0, retire_valid}, 32'd0);
    chk("rst_ill", {31'd0, illegal_instr}, 32'd0);
    chk("rst_rd", {27'd0, retire_rd}, 32'd0);
    chk("rst_data", retire_data, 32'd0);
    chk("rst_op1", alu_operand_1, 32'd0);
    chk("rst_op2", alu_operand_2, 32'd0);
    chk("rst_f", {22'd0, alu_funct7, alu_funct3}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);

    dbg_write(5'd1, 32'd5);
    dbg_write(5'd2, 32'd7);
    dbg_write(5'd0, 32'd33);
    dbg_read(5'd0);
    dbg_read(5'd1);

    issue(32'h002081B3, 1'b0, 1'b0);
    wait_idle();
    dbg_read(5'd3);

    issue(32'h40118233, 1'b1, 1'b0);
    issue(32'h004202B3, 1'b0, 1'b0);
    wait_idle();
    dbg_read(5'd4);
    dbg_read(5'd5);

    issue(32'h00208033, 1'b0, 1'b1);
    wait_idle();
    dbg_read(5'd0);
    dbg_read(5'd7);

    issue(32'h00208003, 1'b1, 1'b0);
    issue(32'h40209233, 1'b1, 1'b0);
    issue(32'h0020C433, 1'b1, 1'b0);
    issue(32'h4011D4B3, 1'b1, 1'b0);
    issue(32'hFFF00313, 1'b0, 1'b0);
    wait_idle();
    for (int i = 1; i < 10; i++) dbg_read(5'(i));

    issue(32'h002081B3, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !alu_enable; i++) @(negedge clock);
    chk("exec_reached", {31'd0, alu_enable}, 32'd1);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_en", {31'd0, alu_enable}, 32'd0);
    chk("arst_ret", {31'd0, retire_valid}, 32'd0);
    q.delete();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    en_cnt = 0;
    prev_en = 1'b0;
    prev_ill = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (LAT + 4) @(negedge clock);
    chk("arst_ready", {31'd0, instr_ready}, 32'd1);
    for (int i = 0; i < 32; i++) dbg_read(5'(i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
